cpu_run_controller: RTL and testbench

//  Sequences the 1-bit CPU core: generates a single-cycle cpu_enable strobe at a divided rate.

---
 rtl/cpu_run_pkg.sv | 16 +
 rtl/button_debouncer.sv | 52 +++++
 rtl/cpu_run_controller.sv | 105 ++++++++++
 tb/tb_cpu_run_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared run-controller types and a counter-width helper.
// Pure declarations; no latency, no backpressure.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } run_state_t;

    // A modulo-n counter needs at least one bit even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces one raw button; press is a one-cycle pulse on accepted 0->1.
// Latency 3+DEBOUNCE cycles from a clean raw edge to press; no backpressure.
module button_debouncer
    import cpu_run_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clock,
    input  logic n_reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_q;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // Any sample matching the accepted level restarts the stability window.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_level_q <= r_level;
            r_press   <= r_level & ~r_level_q;
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/halt/single-step sequencer producing a divided-rate cpu_enable strobe for the 1-bit core.
// Strobe lands on the first tick after a state change; halt_req acts in the tick cycle; no backpressure.
module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter int RATIO       = 2,
    parameter int DEBOUNCE    = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   n_reset,
    input  logic                   btn_run,
    input  logic                   btn_step,
    input  logic                   halt_req,
    output logic                   cpu_enable,
    output logic                   running,
    output logic [COUNT_WIDTH-1:0] step_count
);

    localparam int DW = cnt_width(RATIO);

    logic [DW-1:0]          r_div;
    run_state_t             r_state;
    logic                   r_running;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_tick;
    logic                   w_run_press;
    logic                   w_step_press;
    logic                   w_cpu_enable;

    button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_run_btn (
        .clock   (clock),
        .n_reset (n_reset),
        .raw     (btn_run),
        .level   (),
        .press   (w_run_press)
    );

    button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_step_btn (
        .clock   (clock),
        .n_reset (n_reset),
        .raw     (btn_step),
        .level   (),
        .press   (w_step_press)
    );

    assign w_tick       = (r_div == DW'(RATIO - 1));
    assign w_cpu_enable = w_tick & (((r_state == RUN) & ~halt_req) | (r_state == STEP));

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= HALT;
            r_running <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_cpu_enable) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
            case (r_state)
                HALT: begin
                    if (w_run_press) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end else if (w_step_press) begin
                        r_state <= STEP;
                    end
                end
                RUN: begin
                    if ((w_tick & halt_req) | w_run_press) begin
                        r_state   <= HALT;
                        r_running <= 1'b0;
                    end
                end
                STEP: begin
                    // A run press keeps the pending step alive as the first RUN strobe.
                    if (w_run_press) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end else if (w_tick) begin
                        r_state <= HALT;
                    end
                end
                default: begin
                    r_state   <= HALT;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_enable = w_cpu_enable;
    assign running    = r_running;
    assign step_count = r_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized scoreboard bench for cpu_run_controller with a cycle-level reference model.
// Runs a 16-bit and a 4-bit step counter instance side by side on identical stimulus.
module tb_cpu_run_controller;

    localparam int RATIO  = 2;
    localparam int DEB    = 4;
    localparam int MAXC   = 8192;
    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;

    logic        clock    = 1'b0;
    logic        n_reset  = 1'b1;
    logic        btn_run  = 1'b0;
    logic        btn_step = 1'b0;
    logic        halt_req = 1'b0;
    logic        cpu_enable,  running;
    logic [15:0] step_count;
    logic        cpu_enable4, running4;
    logic [3:0]  step_count4;

    always #5 clock = ~clock;

    cpu_run_controller #(.RATIO(RATIO), .DEBOUNCE(DEB), .COUNT_WIDTH(16)) dut (
        .clock      (clock),
        .n_reset    (n_reset),
        .btn_run    (btn_run),
        .btn_step   (btn_step),
        .halt_req   (halt_req),
        .cpu_enable (cpu_enable),
        .running    (running),
        .step_count (step_count)
    );

    cpu_run_controller #(.RATIO(RATIO), .DEBOUNCE(DEB), .COUNT_WIDTH(4)) dut4 (
        .clock      (clock),
        .n_reset    (n_reset),
        .btn_run    (btn_run),
        .btn_step   (btn_step),
        .halt_req   (halt_req),
        .cpu_enable (cpu_enable4),
        .running    (running4),
        .step_count (step_count4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int     cyc;
        longint cnt;
    } exp_t;

    exp_t   sb[$];
    bit     hist[2][MAXC];
    bit     model_on  = 1'b0;
    bit     en_cur    = 1'b0;
    bit     halt_rand = 1'b0;
    int     cyc       = 0;
    int     mode      = M_HALT;
    longint exp_count = 0;
    bit     m_rp, m_sp, m_tk;

    // A press is seen 4 cycles after the last of DEB consecutive high raw samples that follow a low one.
    function automatic bit pressed(input int b, input int c);
        if (c - 4 - DEB >= 0 && hist[b][c-4-DEB]) return 1'b0;
        for (int k = c - 3 - DEB; k <= c - 4; k++) begin
            if (k < 0 || !hist[b][k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clock) begin
        if (model_on) begin
            if (cyc < MAXC) begin
                hist[0][cyc] = btn_run;
                hist[1][cyc] = btn_step;
            end
            m_rp = pressed(0, cyc);
            m_sp = pressed(1, cyc);
            m_tk = (cyc % RATIO) == (RATIO - 1);
            if (en_cur) exp_count++;
            case (mode)
                M_HALT: if (m_rp) mode = M_RUN; else if (m_sp) mode = M_STEP;
                M_RUN:  if ((m_tk && halt_req) || m_rp) mode = M_HALT;
                default: if (m_rp) mode = M_RUN; else if (m_tk) mode = M_HALT;
            endcase
            cyc++;
            #2;
            if (model_on) begin
                exp_t e;
                en_cur = ((cyc % RATIO) == (RATIO - 1)) &&
                         ((mode == M_RUN && !halt_req) || mode == M_STEP);
                if (en_cur) begin
                    e.cyc = cyc;
                    e.cnt = exp_count;
                    sb.push_back(e);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (model_on && n_reset) begin
            exp_t e;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("missed_strobe", 0, 1);
                void'(sb.pop_front());
            end
            if (cpu_enable || cpu_enable4) begin
                if (sb.size() == 0) begin
                    chk("spurious_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("enable16", cpu_enable, 1);
                    chk("enable4", cpu_enable4, 1);
                    chk("count16", step_count, e.cnt % 65536);
                    chk("count4", step_count4, e.cnt % 16);
                end
            end
            chk("running16", running, mode == M_RUN);
            chk("running4", running4, mode == M_RUN);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            halt_req = halt_rand && ($urandom_range(0, 23) == 0);
        end
    endtask

    task automatic pulse(input bit r, input bit s, input int len);
        btn_run  = r;
        btn_step = s;
        cyc_wait(len);
        btn_run  = 1'b0;
        btn_step = 1'b0;
    endtask

    task automatic do_release();
        @(posedge clock);
        #1;
        n_reset   = 1'b1;
        cyc       = 0;
        mode      = M_HALT;
        exp_count = 0;
        en_cur    = 1'b0;
        sb.delete();
        model_on  = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_enable"},  cpu_enable,  0);
        chk({tag, "_running"}, running,     0);
        chk({tag, "_count"},   step_count,  0);
        chk({tag, "_count4"},  step_count4, 0);
        chk({tag, "_running4"}, running4,   0);
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            int ch;
            ch = $urandom_range(0, 5);
            case (ch)
                0: pulse(1'b1, 1'b0, $urandom_range(DEB, 20));
                1: pulse(1'b0, 1'b1, $urandom_range(DEB, 20));
                2: pulse(1'b1, 1'b1, $urandom_range(DEB, 20));
                3: pulse(1'b1, 1'b0, $urandom_range(1, DEB - 1));
                4: pulse(1'b0, 1'b1, $urandom_range(1, DEB - 1));
                default: ;
            endcase
            cyc_wait($urandom_range(DEB + 6, 40));
        end
    endtask

    initial begin
        #1 n_reset = 1'b0;
        #3;
        check_reset_outputs("reset");
        #8;
        do_release();

        // Idle buttons, then a held run press followed by an asynchronous reset mid-RUN.
        cyc_wait(20);
        pulse(1'b1, 1'b0, 20);
        chk("run_after_press", running, 1);
        cyc_wait(10);
        @(posedge clock);
        #3;
        n_reset  = 1'b0;
        model_on = 1'b0;
        while (sb.size() > 0 && sb[sb.size()-1].cyc == cyc) void'(sb.pop_back());
        chk("sb_drained_before_reset", sb.size(), 0);
        #1;
        check_reset_outputs("async_reset");
        #30;
        do_release();

        halt_rand = 1'b1;
        random_phase(60);
        halt_rand = 1'b0;
        halt_req  = 1'b0;
        cyc_wait(30);

        @(posedge clock);
        #3;
        chk("final_count16", step_count, exp_count % 65536);
        chk("final_count4", step_count4, exp_count % 16);
        while (sb.size() > 0 && sb[sb.size()-1].cyc == cyc) void'(sb.pop_back());
        chk("sb_drained_at_end", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
